fwd_scoreboard: RTL and testbench
=================================

# fwd_scoreboard

Parametrised operand-bypass unit for the in-order MIPS pipeline. It sits between ID and EX and generalises the fixed per-operand forwarding selectors to NRD read ports and DEPTH in-flight stages. It keeps its own shift register of in-flight destination tags. Each cycle it picks the youngest ready producer for every read port, and raises a load-use stall when the youngest matching producer has no result yet. It also keeps a saturating count of hazard-stall cycles.

## Interface
- DW, 32, data width
- AW, 5, register-address width
- NRD, 2, number of read ports (rs, rt, ...)
- DEPTH, 3, in-flight slots tracked (slot 0 = EX, 1 = MEM, 2 = WB)
- LATE_STAGE, 1, first slot at which a "late" result (load, mfc0) is available
- clk  in  1  clock; single clock domain, all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- iss_valid  in  1  an instruction leaves ID into EX this cycle
- iss_wr  in  1  the issuing instruction writes a GPR
- iss_dst  in  AW  destination register of the issuing instruction
- iss_late  in  1  the result is only available from slot LATE_STAGE onward
- pipe_stall  in  1  global freeze (cache miss, multi-cycle op)
- flush  in  1  exception or branch squash; kill every in-flight tag
- stage_data  in  DEPTH*DW  result carried by each slot's pipeline register; slice k belongs to slot k
- rd_addr  in  NRD*AW  source register per read port
- rd_gpr  in  NRD*DW  register-file read data per port
- rd_data  out  NRD*DW  forwarded operand per port
- rd_fwd  out  NRD  port p takes its data from a slot rather than from rd_gpr
- hazard_stall  out  1  hold ID and PC; the block inserts a bubble into EX
- stall_cnt  out  32  saturating count of cycles with hazard_stall=1

## Operation
- State per slot k:
  - v[k]: valid
  - d[k]: destination, AW bits
  - l[k]: late flag
- Match on port p, slot k: v[k] && d[k]==rd_addr[p] && rd_addr[p]!=0.
- Ready on slot k: !l[k] || k>=LATE_STAGE.
- Selection per port: the lowest-index matching slot wins.
  - Winner ready: rd_data[p]=stage_data[k], rd_fwd[p]=1.
  - No match: rd_data[p]=rd_gpr[p], rd_fwd[p]=0.
  - Winner not ready: the port is blocked, rd_data[p]=rd_gpr[p], rd_fwd[p]=0.
- An older ready match never overrides a younger blocked match.
- hazard_stall = OR of the blocked signals over all ports, gated by !pipe_stall.
- rd_addr=0 always reads rd_gpr, even when a slot targets $0.
- Tag update priority, highest first:
  - rst: clear all v[k].
  - flush: clear all v[k].
  - pipe_stall: hold all tags.
  - Otherwise shift: slot k+1 takes slot k, and slot DEPTH-1 is dropped.
    - Slot 0 loads {iss_valid && iss_wr && !hazard_stall, iss_dst, iss_late}.
    - While hazard_stall=1, slot 0 loads a bubble (v=0) and iss_valid is ignored.
- stall_cnt:
  - Increments on every edge where hazard_stall=1 and rst=0.
  - Saturates at 0xFFFFFFFF.
  - flush does not clear it; only rst does.

## Timing
- Reset values: every v[k]=0, stall_cnt=0, hazard_stall=0, rd_fwd=0, rd_data=rd_gpr.
- rd_data, rd_fwd and hazard_stall are combinational from the registered tags and the current inputs; no added latency.
- Tag state changes one edge after the issue/flush/stall inputs.
- Load-use case: a late producer in slot 0 followed by a dependent instruction stalls exactly 1 cycle when LATE_STAGE=1. The next cycle the producer sits in slot 1, is ready, and is forwarded.
- Simultaneous flush and pipe_stall: flush wins; all tags are cleared.
- Simultaneous flush and hazard_stall: the tags clear and stall_cnt still counts that cycle.
- Reset mid-stall: the next cycle has hazard_stall=0 and stall_cnt=0.
- pipe_stall=1 suppresses hazard_stall, so stall_cnt does not count frozen cycles.
- A slot leaving index DEPTH-1 is forgotten; the register file must already hold its value (write-first RF).

## Test plan
- Back-to-back ALU dependency, default parameters:
  - Stimulus: issue add $3 with slot-0 data 0x11, then read rs=$3.
  - Response: rd_data[0]=0x11, rd_fwd[0]=1, hazard_stall=0.
- Load-use:
  - Stimulus: issue a late write to $5, then read rt=$5.
  - Response: hazard_stall=1 for 1 cycle and stall_cnt=1. Next cycle rd_data[1]=stage_data[1] and rd_fwd[1]=1.
- Youngest wins:
  - Stimulus: $7 in slot 0 (data 0xA) and in slot 2 (data 0xB); read $7 on both ports.
  - Response: both ports return 0xA.
- $0 and no match:
  - Stimulus: slot 0 writes $0; read $0 and $9 with rd_gpr=0x0 and 0x99.
  - Response: rd_data = 0x0 and 0x99, rd_fwd=00.
- Flush with stall:
  - Stimulus: assert a load-use stall together with flush and pipe_stall.
  - Response: next cycle all tags are invalid, hazard_stall=0, and stall_cnt is unchanged (pipe_stall gated the stall).
- Parameter sweep and saturation:
  - Stimulus: NRD=3, DEPTH=4, LATE_STAGE=2, with a late producer.
  - Response: the consumer stalls 2 cycles and is then forwarded from slot 2.
  - Stimulus: force stall_cnt near 0xFFFFFFFF.
  - Response: stall_cnt holds at 0xFFFFFFFF.

Source files
------------

// File: rtl/fwd_scoreboard.sv
// Operand-bypass scoreboard between ID and EX: tracks in-flight destination tags,
// forwards the youngest ready producer per read port and raises load-use stalls.
module fwd_scoreboard #(
  parameter int DW         = 32,
  parameter int AW         = 5,
  parameter int NRD        = 2,
  parameter int DEPTH      = 3,
  parameter int LATE_STAGE = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iss_valid,
  input  logic                iss_wr,
  input  logic [AW-1:0]       iss_dst,
  input  logic                iss_late,
  input  logic                pipe_stall,
  input  logic                flush,
  input  logic [DEPTH*DW-1:0] stage_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  input  logic [NRD*DW-1:0]   rd_gpr,
  output logic [NRD*DW-1:0]   rd_data,
  output logic [NRD-1:0]      rd_fwd,
  output logic                hazard_stall,
  output logic [31:0]         stall_cnt
);

  logic [DEPTH-1:0]         r_v;
  logic [DEPTH-1:0][AW-1:0] r_d;
  logic [DEPTH-1:0]         r_l;
  logic [31:0]              r_stall_cnt;

  logic [NRD*DW-1:0] w_data;
  logic [NRD-1:0]    w_fwd;
  logic [NRD-1:0]    w_blocked;
  logic              w_hazard;

  // Slot 0 is the youngest producer, so the first hit in ascending order decides
  // the port even if an older slot would be ready.
  always_comb begin
    logic          hit;
    logic [AW-1:0] addr;
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_data    = rd_gpr;
    w_fwd     = '0;
    w_blocked = '0;
    for (int p = 0; p < NRD; p++) begin
      hit  = 1'b0;
      addr = rd_addr[p*AW +: AW];
      for (int k = 0; k < DEPTH; k++) begin
        if (!hit && r_v[k] && (r_d[k] == addr) && (addr != '0)) begin
          hit = 1'b1;
          if (!r_l[k] || (k >= LATE_STAGE)) begin
            w_fwd[p]             = 1'b1;
            w_data[p*DW +: DW]   = stage_data[k*DW +: DW];
          end else begin
            w_blocked[p] = 1'b1;
          end
        end
      end
    end
  end

  assign w_hazard = (|w_blocked) && !pipe_stall;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every slot shifts
    // from its pre-edge neighbour.
    if (rst) begin
      // NOTE: only the valid bits are reset; destination and late flags are
      // qualified by v and need no reset.
      r_v <= '0;
    end else if (flush) begin
      r_v <= '0;
    end else if (!pipe_stall) begin
      for (int k = DEPTH - 1; k > 0; k--) begin
        r_v[k] <= r_v[k-1];
        r_d[k] <= r_d[k-1];
        r_l[k] <= r_l[k-1];
      end
      r_v[0] <= iss_valid && iss_wr && !w_hazard;
      r_d[0] <= iss_dst;
      r_l[0] <= iss_late;
    end
  end

  // Flush deliberately leaves the counter alone; it only measures stall cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
    end else if (w_hazard && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign rd_data      = w_data;
  assign rd_fwd       = w_fwd;
  assign hazard_stall = w_hazard;
  assign stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: queue-based reference model compared every
// cycle under random stimulus, plus directed literal checks and a parameter sweep.
module tb_fwd_scoreboard;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int NRD   = 2;
  localparam int DEPTH = 3;
  localparam int LATE  = 1;
  localparam int NRD2   = 3;
  localparam int DEPTH2 = 4;
  localparam int LATE2  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // default-parameter instance
  logic                rst, iss_valid, iss_wr, iss_late, pipe_stall, flush;
  logic [AW-1:0]       iss_dst;
  logic [DEPTH*DW-1:0] stage_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*DW-1:0]   rd_gpr, rd_data;
  logic [NRD-1:0]      rd_fwd;
  logic                hazard_stall;
  logic [31:0]         stall_cnt;

  // swept-parameter instance
  logic                 b_rst, b_iss_valid, b_iss_wr, b_iss_late, b_pipe_stall, b_flush;
  logic [AW-1:0]        b_iss_dst;
  logic [DEPTH2*DW-1:0] b_stage_data;
  logic [NRD2*AW-1:0]   b_rd_addr;
  logic [NRD2*DW-1:0]   b_rd_gpr, b_rd_data;
  logic [NRD2-1:0]      b_rd_fwd;
  logic                 b_hazard_stall;
  logic [31:0]          b_stall_cnt;

  fwd_scoreboard #(.DW(DW), .AW(AW), .NRD(NRD), .DEPTH(DEPTH), .LATE_STAGE(LATE)) dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_wr(iss_wr), .iss_dst(iss_dst),
    .iss_late(iss_late), .pipe_stall(pipe_stall), .flush(flush), .stage_data(stage_data),
    .rd_addr(rd_addr), .rd_gpr(rd_gpr), .rd_data(rd_data), .rd_fwd(rd_fwd),
    .hazard_stall(hazard_stall), .stall_cnt(stall_cnt)
  );

  fwd_scoreboard #(.DW(DW), .AW(AW), .NRD(NRD2), .DEPTH(DEPTH2), .LATE_STAGE(LATE2)) dut2 (
    .clk(clk), .rst(b_rst), .iss_valid(b_iss_valid), .iss_wr(b_iss_wr), .iss_dst(b_iss_dst),
    .iss_late(b_iss_late), .pipe_stall(b_pipe_stall), .flush(b_flush),
    .stage_data(b_stage_data), .rd_addr(b_rd_addr), .rd_gpr(b_rd_gpr), .rd_data(b_rd_data),
    .rd_fwd(b_rd_fwd), .hazard_stall(b_hazard_stall), .stall_cnt(b_stall_cnt)
  );

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: list of in-flight producers, youngest at the front.
  typedef struct {
    bit            v;
    logic [AW-1:0] d;
    bit            l;
  } tag_t;

  tag_t        m_tags[$];
  logic [31:0] m_cnt;

  function automatic void model_eval(output logic [NRD*DW-1:0] e_data,
                                     output logic [NRD-1:0] e_fwd, output logic e_haz);
    logic          blocked;
    logic [AW-1:0] a;
    e_data  = rd_gpr;
    e_fwd   = '0;
    blocked = 1'b0;
    for (int p = 0; p < NRD; p++) begin
      a = rd_addr[p*AW +: AW];
      if (a != '0) begin
        for (int k = 0; k < m_tags.size(); k++) begin
          if (m_tags[k].v && m_tags[k].d == a) begin
            if (!m_tags[k].l || k >= LATE) begin
              e_data[p*DW +: DW] = stage_data[k*DW +: DW];
              e_fwd[p]           = 1'b1;
            end else begin
              blocked = 1'b1;
            end
            break;
          end
        end
      end
    end
    e_haz = blocked && !pipe_stall;
  endfunction

  // model state update on every rising edge
  initial begin
    tag_t t;
    for (int k = 0; k < DEPTH; k++) begin
      t.v = 1'b0; t.d = '0; t.l = 1'b0;
      m_tags.push_back(t);
    end
    m_cnt = '0;
    forever begin
      logic [NRD*DW-1:0] ed;
      logic [NRD-1:0]    ef;
      logic              eh;
      @(posedge clk);
      model_eval(ed, ef, eh);
      if (rst) begin
        for (int k = 0; k < m_tags.size(); k++) m_tags[k].v = 1'b0;
        m_cnt = '0;
      end else begin
        if (eh && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
        if (flush) begin
          for (int k = 0; k < m_tags.size(); k++) m_tags[k].v = 1'b0;
        end else if (!pipe_stall) begin
          void'(m_tags.pop_back());
          t.v = iss_valid && iss_wr && !eh;
          t.d = iss_dst;
          t.l = iss_late;
          m_tags.push_front(t);
        end
      end
    end
  end

  // compare process: every falling edge once the DUT is out of its unknown start state
  initial begin
    forever begin
      logic [NRD*DW-1:0] ed;
      logic [NRD-1:0]    ef;
      logic              eh;
      @(negedge clk);
      if (chk_en) begin
        model_eval(ed, ef, eh);
        check("model rd_data", rd_data, ed);
        check("model rd_fwd", rd_fwd, ef);
        check("model hazard_stall", hazard_stall, eh);
        check("model stall_cnt", stall_cnt, m_cnt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic idle();
    iss_valid = 1'b0; iss_wr = 1'b0; iss_dst = '0; iss_late = 1'b0;
    flush = 1'b0; pipe_stall = 1'b0; rd_addr = '0;
  endtask

  task automatic issue(input logic [AW-1:0] dst, input logic late);
    iss_valid = 1'b1; iss_wr = 1'b1; iss_dst = dst; iss_late = late;
  endtask

  initial begin
    rst = 1'b1; idle(); rd_gpr = {32'h22, 32'h21}; stage_data = '0;
    b_rst = 1'b1; b_iss_valid = 1'b0; b_iss_wr = 1'b0; b_iss_dst = '0; b_iss_late = 1'b0;
    b_pipe_stall = 1'b0; b_flush = 1'b0; b_stage_data = '0; b_rd_addr = '0;
    b_rd_gpr = {32'hC2, 32'hC1, 32'hC0};

    tick(); chk_en = 1'b1;
    tick(); rst = 1'b0; settle();
    check("reset hazard_stall", hazard_stall, 1'b0);
    check("reset rd_fwd", rd_fwd, 2'b00);
    check("reset rd_data", rd_data, 64'h0000_0022_0000_0021);
    check("reset stall_cnt", stall_cnt, 32'd0);

    // back-to-back ALU dependency
    tick(); issue(5'd3, 1'b0);
    tick(); idle(); stage_data = {32'h0, 32'h0, 32'h11}; rd_addr = {5'd0, 5'd3}; settle();
    check("alu rd_data0", rd_data[31:0], 32'h11);
    check("alu rd_fwd0", rd_fwd[0], 1'b1);
    check("alu hazard", hazard_stall, 1'b0);

    // load-use: one stall cycle, then forwarded from slot 1
    tick(); issue(5'd5, 1'b1); rd_addr = '0;
    tick(); issue(5'd6, 1'b0); rd_addr = {5'd5, 5'd0}; settle();
    check("lu stall", hazard_stall, 1'b1);
    check("lu blocked fwd", rd_fwd, 2'b00);
    check("lu blocked data1", rd_data[63:32], 32'h22);
    check("lu cnt before", stall_cnt, 32'd0);
    tick(); stage_data = {32'h0, 32'h55, 32'h0}; settle();
    check("lu released", hazard_stall, 1'b0);
    check("lu fwd1", rd_fwd[1], 1'b1);
    check("lu data1", rd_data[63:32], 32'h55);
    check("lu cnt after", stall_cnt, 32'd1);

    // youngest producer wins
    tick(); issue(5'd7, 1'b0); rd_addr = '0;
    tick(); issue(5'd8, 1'b0);
    tick(); issue(5'd7, 1'b0);
    tick(); idle(); rd_addr = {5'd7, 5'd7}; stage_data = {32'hB, 32'hC, 32'hA}; settle();
    check("youngest data", rd_data, {32'hA, 32'hA});
    check("youngest fwd", rd_fwd, 2'b11);

    // $0 never forwards; unmatched register reads the file
    tick(); issue(5'd0, 1'b0);
    tick(); idle(); rd_addr = {5'd9, 5'd0}; rd_gpr = {32'h99, 32'h0};
    stage_data = {32'hB, 32'hA, 32'hDEAD}; settle();
    check("zero/nomatch data", rd_data, {32'h99, 32'h0});
    check("zero/nomatch fwd", rd_fwd, 2'b00);

    // flush with pipe_stall during a load-use: stall gated, tags cleared, count held
    tick(); issue(5'd5, 1'b1);
    tick(); idle(); rd_addr = {5'd5, 5'd0}; flush = 1'b1; pipe_stall = 1'b1; settle();
    check("flush+freeze hazard", hazard_stall, 1'b0);
    tick(); idle(); rd_addr = {5'd5, 5'd0}; settle();
    check("post flush hazard", hazard_stall, 1'b0);
    check("post flush fwd", rd_fwd, 2'b00);
    check("post flush cnt", stall_cnt, 32'd1);

    // flush together with a real hazard still counts the cycle
    tick(); issue(5'd5, 1'b1);
    tick(); idle(); rd_addr = {5'd5, 5'd0}; flush = 1'b1; settle();
    check("flush+hazard stall", hazard_stall, 1'b1);
    tick(); idle(); rd_addr = {5'd5, 5'd0}; settle();
    check("flush+hazard after", hazard_stall, 1'b0);
    check("flush+hazard cnt", stall_cnt, 32'd2);

    // reset in the middle of a stall
    tick(); issue(5'd5, 1'b1);
    tick(); idle(); rd_addr = {5'd5, 5'd0}; rst = 1'b1; settle();
    check("rst mid-stall before", hazard_stall, 1'b1);
    tick(); rst = 1'b0; idle(); rd_addr = {5'd5, 5'd0}; settle();
    check("rst mid-stall hazard", hazard_stall, 1'b0);
    check("rst mid-stall cnt", stall_cnt, 32'd0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst        = ($urandom_range(0, 199) == 0);
      flush      = ($urandom_range(0, 29) == 0);
      pipe_stall = ($urandom_range(0, 9) == 0);
      iss_valid  = ($urandom_range(0, 3) != 0);
      iss_wr     = ($urandom_range(0, 4) != 0);
      iss_dst    = AW'($urandom_range(0, 7));
      iss_late   = ($urandom_range(0, 2) == 0);
      rd_addr    = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      rd_gpr     = {$urandom, $urandom};
      stage_data = {$urandom, $urandom, $urandom};
    end
    tick(); rst = 1'b0; idle();

    // saturation: preload the counter near its ceiling, then stall repeatedly
    tick();
    force dut.r_stall_cnt = 32'hFFFF_FFFD;
    m_cnt = 32'hFFFF_FFFD;
    #1 release dut.r_stall_cnt;
    for (int i = 0; i < 4; i++) begin
      tick(); issue(5'd5, 1'b1); rd_addr = '0;
      tick(); idle(); rd_addr = {5'd5, 5'd0};
    end
    tick(); idle(); settle();
    check("saturated cnt", stall_cnt, 32'hFFFF_FFFF);

    // parameter sweep: NRD=3, DEPTH=4, LATE_STAGE=2 -> two stall cycles
    tick(); b_rst = 1'b0; settle();
    check("sweep reset hazard", b_hazard_stall, 1'b0);
    check("sweep reset cnt", b_stall_cnt, 32'd0);
    tick(); b_iss_valid = 1'b1; b_iss_wr = 1'b1; b_iss_dst = 5'd4; b_iss_late = 1'b1;
    tick(); b_iss_dst = 5'd9; b_iss_late = 1'b0; b_rd_addr = {5'd4, 5'd0, 5'd0}; settle();
    check("sweep stall 1", b_hazard_stall, 1'b1);
    check("sweep stall 1 fwd", b_rd_fwd, 3'b000);
    tick(); settle();
    check("sweep stall 2", b_hazard_stall, 1'b1);
    check("sweep cnt 1", b_stall_cnt, 32'd1);
    tick(); b_stage_data = {32'h4444, 32'h3333, 32'h2222, 32'h1111}; settle();
    check("sweep released", b_hazard_stall, 1'b0);
    check("sweep fwd", b_rd_fwd, 3'b100);
    check("sweep data2", b_rd_data[95:64], 32'h3333);
    check("sweep gpr ports", b_rd_data[63:0], {32'hC1, 32'hC0});
    check("sweep cnt 2", b_stall_cnt, 32'd2);

    tick(); chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
